// File: rtl/cordic_unit.sv
// -----------------------------------------------------------------------------
// cordic_unit
//
// Iterative CORDIC functional unit for the execute stage. It accepts one
// request from issue, runs ITER micro-rotations (one per cycle) and returns
// the result on a dedicated scoreboard writeback port. Only one operation is
// in flight at a time.
//
//   op 00 COS   : rotation mode, result = x
//   op 01 SIN   : rotation mode, result = y
//   op 10 ATAN2 : vectoring mode, result = z (only when CORDIC_VECTOR_EN is
//                 defined; otherwise handled like the reserved op)
//   op 11       : reserved, full latency, result 0
//
// Optional feature macro: CORDIC_VECTOR_EN (enables ATAN2 vectoring mode).
//
// Fixed-point format is Q2.(DATA_W-2) signed. The datapath carries 2 guard
// bits (DATA_W+2 wide) and the final value is saturated to DATA_W bits and
// sign-extended to XLEN.
//
// Handshake: a request is accepted on a rising clock edge when the unit is
// in IDLE (cordic_ready_o=1), cordic_valid_i=1 and flush_i=0. The result is
// presented with a single-cycle cordic_wb_valid_o strobe exactly ITER+1
// cycles after the accept cycle; writeback has no backpressure.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   flush_i               kill the in-flight operation (no writeback)
//   cordic_valid_i        issue request
//   cordic_ready_o        unit is idle and can accept a request
//   op_i                  operation select
//   operand_a_i           angle (COS/SIN) or x (ATAN2), low DATA_W bits used
//   operand_b_i           y (ATAN2), low DATA_W bits used
//   trans_id_i            scoreboard transaction ID of the request
//   cordic_result_o       result, sign-extended from DATA_W
//   cordic_trans_id_o     transaction ID of the result
//   cordic_wb_valid_o     one-cycle writeback strobe
// -----------------------------------------------------------------------------
module cordic_unit #(
  parameter int XLEN       = 64,
  parameter int DATA_W     = 32,
  parameter int ITER       = 16,
  parameter int TRANS_ID_W = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  cordic_valid_i,
  output logic                  cordic_ready_o,
  input  logic [1:0]            op_i,
  input  logic [XLEN-1:0]       operand_a_i,
  input  logic [XLEN-1:0]       operand_b_i,
  input  logic [TRANS_ID_W-1:0] trans_id_i,
  output logic [XLEN-1:0]       cordic_result_o,
  output logic [TRANS_ID_W-1:0] cordic_trans_id_o,
  output logic                  cordic_wb_valid_o
);

  localparam int W     = DATA_W + 2;
  localparam int FRAC  = DATA_W - 2;
  localparam int CNT_W = $clog2(ITER);

  localparam logic [1:0] OP_COS = 2'b00;
  localparam logic [1:0] OP_SIN = 2'b01;
`ifdef CORDIC_VECTOR_EN
  localparam logic [1:0] OP_ATAN2 = 2'b10;
`endif

  // High-precision constants with 96 fractional bits; every fixed-point
  // constant of the datapath is rounded from these at elaboration.
  localparam logic [127:0] PI_Q96 = 128'h3_243F6A88_85A308D3_13198A2E;
  localparam logic [127:0] K_Q96  = 128'h9B74EDA8 << 64;

  function automatic logic [W-1:0] q96_to_fix(input logic [127:0] v);
    logic [127:0] r;
    r = (v + (128'd1 << (95 - FRAC))) >> (96 - FRAC);
    return r[W-1:0];
  endfunction

  // atan(2^-i): pi/4 for i=0, otherwise the alternating Taylor series
  // x - x^3/3 + x^5/5 ... with x = 2^-i, evaluated in 96-bit fraction.
  function automatic logic [W-1:0] atan_fix(input int i);
    logic [127:0] acc;
    logic [127:0] term;
    acc  = '0;
    term = '0;
    if (i == 0) begin
      acc = PI_Q96 >> 2;
    end else begin
      for (int k = 0; k < 48; k++) begin
        if (i * (2 * k + 1) <= 96) begin
          term = ((128'd1 << 96) >> (i * (2 * k + 1))) / 128'(2 * k + 1);
          if (k % 2 == 0) acc = acc + term;
          else            acc = acc - term;
        end
      end
    end
    return q96_to_fix(acc);
  endfunction

  localparam logic signed [W-1:0] HALF_PI = q96_to_fix(PI_Q96 >> 1);
  localparam logic signed [W-1:0] K_FIX   = q96_to_fix(K_Q96);

  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [W-1:0] atan_tbl [ITER];

  for (genvar g = 0; g < ITER; g++) begin : g_atan
    localparam logic signed [W-1:0] ATAN_G = atan_fix(g);
    assign atan_tbl[g] = ATAN_G;
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [1:0]              op_q;
  logic [TRANS_ID_W-1:0]   id_q;
  logic signed [W-1:0]     x_q, y_q, z_q;
  logic [XLEN-1:0]         result_q;
  logic [TRANS_ID_W-1:0]   res_id_q;
`ifdef CORDIC_VECTOR_EN
  logic                    a_pos_q;
  logic                    a_pos_d;
`endif

  logic                    last_iter;
  logic                    accept;
  logic signed [W-1:0]     a_ext, angle_clamped;
  logic signed [W-1:0]     x_init, y_init, z_init;
  logic signed [W-1:0]     x_sh, y_sh, x_n, y_n, z_n;
  logic                    dir_pos;
  logic signed [W-1:0]     sel;
  logic [DATA_W-1:0]       sat;
  logic                    overflow;
  logic [XLEN-1:0]         result_d;
  logic                    unused_hi;

`ifdef CORDIC_VECTOR_EN
  logic signed [W-1:0]     b_ext;
  assign b_ext = {{2{operand_b_i[DATA_W-1]}}, operand_b_i[DATA_W-1:0]};
  assign unused_hi = ^{operand_a_i[XLEN-1:DATA_W], operand_b_i[XLEN-1:DATA_W]};
`else
  assign unused_hi = ^{operand_a_i[XLEN-1:DATA_W], operand_b_i};
`endif

  assign last_iter = (cnt_q == CNT_W'(ITER - 1));
  assign accept    = (state_q == S_IDLE) && cordic_valid_i && !flush_i;
  assign a_ext     = {{2{operand_a_i[DATA_W-1]}}, operand_a_i[DATA_W-1:0]};

  // Next-state logic. Flush wins over everything, including DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cordic_valid_i) state_d = S_BUSY;
      S_BUSY:  if (last_iter)      state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  // Initial x/y/z for the request being accepted.
  always_comb begin
    angle_clamped = a_ext;
    if (a_ext > HALF_PI)       angle_clamped = HALF_PI;
    else if (a_ext < -HALF_PI) angle_clamped = -HALF_PI;

    x_init = K_FIX;
    y_init = '0;
    z_init = angle_clamped;
`ifdef CORDIC_VECTOR_EN
    a_pos_d = !a_ext[W-1] && (a_ext != '0);
    if (op_i == OP_ATAN2) begin
      x_init = a_ext;
      y_init = b_ext;
      z_init = '0;
    end
`endif
  end

  // One micro-rotation. dir_pos means d = +1.
  always_comb begin
    x_sh = x_q >>> cnt_q;
    y_sh = y_q >>> cnt_q;
`ifdef CORDIC_VECTOR_EN
    if (op_q == OP_ATAN2) dir_pos = y_q[W-1];
    else                  dir_pos = !z_q[W-1];
`else
    dir_pos = !z_q[W-1];
`endif
    if (dir_pos) begin
      x_n = x_q - y_sh;
      y_n = y_q + x_sh;
      z_n = z_q - atan_tbl[cnt_q];
    end else begin
      x_n = x_q + y_sh;
      y_n = y_q - x_sh;
      z_n = z_q + atan_tbl[cnt_q];
    end
  end

  // Result select from the final rotation, saturate, sign-extend.
  always_comb begin
    sel = '0;
    case (op_q)
      OP_COS:   sel = x_n;
      OP_SIN:   sel = y_n;
`ifdef CORDIC_VECTOR_EN
      OP_ATAN2: sel = a_pos_q ? z_n : '0;
`endif
      default:  sel = '0;
    endcase
    overflow = (sel[W-1:DATA_W-1] != {(W-DATA_W+1){sel[W-1]}});
    if (overflow) sat = sel[W-1] ? SAT_MIN : SAT_MAX;
    else          sat = sel[DATA_W-1:0];
    result_d = {{(XLEN-DATA_W){sat[DATA_W-1]}}, sat};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      id_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      result_q <= '0;
      res_id_q <= '0;
`ifdef CORDIC_VECTOR_EN
      a_pos_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= op_i;
        id_q  <= trans_id_i;
        x_q   <= x_init;
        y_q   <= y_init;
        z_q   <= z_init;
        cnt_q <= '0;
`ifdef CORDIC_VECTOR_EN
        a_pos_q <= a_pos_d;
`endif
      end else if (state_q == S_BUSY) begin
        x_q   <= x_n;
        y_q   <= y_n;
        z_q   <= z_n;
        cnt_q <= last_iter ? '0 : cnt_q + 1'b1;
        // Result/ID only change when DONE is actually entered.
        if (last_iter && !flush_i) begin
          result_q <= result_d;
          res_id_q <= id_q;
        end
      end
      if (flush_i) cnt_q <= '0;
    end
  end

  assign cordic_ready_o    = (state_q == S_IDLE);
  assign cordic_wb_valid_o = (state_q == S_DONE) && !flush_i && !rst_i;
  assign cordic_result_o   = result_q;
  assign cordic_trans_id_o = res_id_q;

endmodule

// File: tb/tb_cordic_unit.sv
// -----------------------------------------------------------------------------
// tb_cordic_unit
//
// Directed bench for cordic_unit. Expected writebacks (ID, result, tolerance,
// cycle) are queued when a request is driven and checked when the strobe is
// due; every other cycle the strobe must be low.
// -----------------------------------------------------------------------------
module tb_cordic_unit;

  localparam int XLEN       = 64;
  localparam int DATA_W     = 32;
  localparam int ITER       = 16;
  localparam int TRANS_ID_W = 3;
  localparam int LAT        = ITER + 1;

  localparam logic [1:0] OP_COS   = 2'b00;
  localparam logic [1:0] OP_SIN   = 2'b01;
  localparam logic [1:0] OP_ATAN2 = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [63:0] TOL = 64'h1_0000;

  // clock / reset / DUT
  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic                  flush_i;
  logic                  cordic_valid_i;
  logic                  cordic_ready_o;
  logic [1:0]            op_i;
  logic [XLEN-1:0]       operand_a_i;
  logic [XLEN-1:0]       operand_b_i;
  logic [TRANS_ID_W-1:0] trans_id_i;
  logic [XLEN-1:0]       cordic_result_o;
  logic [TRANS_ID_W-1:0] cordic_trans_id_o;
  logic                  cordic_wb_valid_o;

  always #5 clk_i = ~clk_i;

  cordic_unit #(
    .XLEN(XLEN), .DATA_W(DATA_W), .ITER(ITER), .TRANS_ID_W(TRANS_ID_W)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .flush_i(flush_i),
    .cordic_valid_i(cordic_valid_i),
    .cordic_ready_o(cordic_ready_o),
    .op_i(op_i),
    .operand_a_i(operand_a_i),
    .operand_b_i(operand_b_i),
    .trans_id_i(trans_id_i),
    .cordic_result_o(cordic_result_o),
    .cordic_trans_id_o(cordic_trans_id_o),
    .cordic_wb_valid_o(cordic_wb_valid_o)
  );

  // scoreboard
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [XLEN-1:0]       exp_q[$];
  logic [XLEN-1:0]       tol_q[$];
  logic [TRANS_ID_W-1:0] exp_id_q[$];
  int                    exp_cyc_q[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_result(input logic [63:0] got, input logic [63:0] exp,
                              input logic [63:0] tol);
    logic signed [63:0] diff;
    logic [63:0]        mag;
    logic               in_tol;
    diff   = $signed(got) - $signed(exp);
    mag    = diff[63] ? -diff : diff;
    in_tol = (mag <= tol);
    checks++;
    assert (in_tol === 1'b1) else begin
      failures++;
      $error("FAIL wb_result got=%0h exp=%0h tol=%0h", got, exp, tol);
    end
  endtask

  // Advance one cycle and sample #1 after the edge; check the writeback port.
  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
    if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
      check_val("wb_valid_due", {63'd0, cordic_wb_valid_o}, 64'd1);
      if (cordic_wb_valid_o === 1'b1) begin
        check_val("wb_trans_id", {61'd0, cordic_trans_id_o}, {61'd0, exp_id_q[0]});
        check_result(cordic_result_o, exp_q[0], tol_q[0]);
      end
      void'(exp_q.pop_front());
      void'(tol_q.pop_front());
      void'(exp_id_q.pop_front());
      void'(exp_cyc_q.pop_front());
    end else begin
      check_val("wb_valid_quiet", {63'd0, cordic_wb_valid_o}, 64'd0);
    end
  endtask

  // driver: present a request for one cycle (the current cycle T).
  task automatic issue(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [TRANS_ID_W-1:0] id, input bit push,
                       input logic [63:0] exp, input logic [63:0] tol);
    op_i           = op;
    operand_a_i    = a;
    operand_b_i    = b;
    trans_id_i     = id;
    cordic_valid_i = 1'b1;
    if (push) begin
      exp_q.push_back(exp);
      tol_q.push_back(tol);
      exp_id_q.push_back(id);
      exp_cyc_q.push_back(cyc + LAT);
    end
    tick();
    cordic_valid_i = 1'b0;
  endtask

  // full operation: accept at T, ready low at T+1, writeback at T+17,
  // ready high again at T+18.
  task automatic run_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [TRANS_ID_W-1:0] id,
                        input logic [63:0] exp, input logic [63:0] tol);
    issue(op, a, b, id, 1'b1, exp, tol);
    check_val("ready_busy", {63'd0, cordic_ready_o}, 64'd0);
    repeat (LAT) tick();
    check_val("ready_after_done", {63'd0, cordic_ready_o}, 64'd1);
  endtask

  initial begin
    rst_i          = 1'b1;
    flush_i        = 1'b0;
    cordic_valid_i = 1'b0;
    op_i           = '0;
    operand_a_i    = '0;
    operand_b_i    = '0;
    trans_id_i     = '0;

    // reset state
    repeat (3) tick();
    rst_i = 1'b0;
    tick();
    check_val("rst_ready", {63'd0, cordic_ready_o}, 64'd1);
    check_val("rst_result", cordic_result_o, 64'd0);
    check_val("rst_trans_id", {61'd0, cordic_trans_id_o}, 64'd0);

    // rotation mode
    run_op(OP_COS, 64'h0000_0000, 64'd0, 3'd5, 64'h0000_0000_4000_0000, TOL);
    run_op(OP_SIN, 64'h2182_A470, 64'd0, 3'd1, 64'h0000_0000_2000_0000, TOL);
    run_op(OP_SIN, 64'hDE7D_5B90, 64'd0, 3'd2, 64'hFFFF_FFFF_E000_0000, TOL);
    run_op(OP_SIN, 64'h7FFF_FFFF, 64'd0, 3'd3, 64'h0000_0000_4000_0000, TOL);
    run_op(OP_COS, 64'h7FFF_FFFF, 64'd0, 3'd4, 64'h0000_0000_0000_0000, TOL);
    run_op(OP_COS, 64'hFFFF_FFFF_DE7D_5B90, 64'd0, 3'd6, 64'h0000_0000_376C_F5D1, TOL);
    run_op(OP_RSVD, 64'h2182_A470, 64'd0, 3'd7, 64'd0, 64'd0);

    // ATAN2
`ifdef CORDIC_VECTOR_EN
    run_op(OP_ATAN2, 64'h4000_0000, 64'h4000_0000, 3'd2, 64'h0000_0000_3243_F6A9, TOL);
    run_op(OP_ATAN2, 64'h4000_0000, 64'hC000_0000, 3'd3, 64'hFFFF_FFFF_CDBC_0957, TOL);
`else
    run_op(OP_ATAN2, 64'h4000_0000, 64'h4000_0000, 3'd2, 64'd0, 64'd0);
`endif
    run_op(OP_ATAN2, 64'h0000_0000, 64'h0000_0001, 3'd4, 64'd0, 64'd0);

    // flush at T+5, new request at T+6 writes back at T+23
    issue(OP_COS, 64'd0, 64'd0, 3'd1, 1'b0, 64'd0, 64'd0);
    repeat (4) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check_val("ready_after_flush", {63'd0, cordic_ready_o}, 64'd1);
    run_op(OP_COS, 64'h2182_A470, 64'd0, 3'd2, 64'h0000_0000_376C_F5D1, TOL);

    // request together with flush is dropped
    op_i           = OP_SIN;
    trans_id_i     = 3'd7;
    cordic_valid_i = 1'b1;
    flush_i        = 1'b1;
    tick();
    cordic_valid_i = 1'b0;
    flush_i        = 1'b0;
    check_val("flush_blocks_accept", {63'd0, cordic_ready_o}, 64'd1);
    repeat (LAT + 2) tick();

    // reset at T+8 clears result and ID
    issue(OP_COS, 64'd0, 64'd0, 3'd3, 1'b0, 64'd0, 64'd0);
    repeat (7) tick();
    check_val("id_held_busy", {61'd0, cordic_trans_id_o}, 64'd2);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_val("rst_mid_result", cordic_result_o, 64'd0);
    check_val("rst_mid_trans_id", {61'd0, cordic_trans_id_o}, 64'd0);
    check_val("rst_mid_ready", {63'd0, cordic_ready_o}, 64'd1);
    repeat (LAT + 2) tick();

    // request held high: accepted every ITER+2 cycles, IDs in order
    op_i           = OP_COS;
    operand_a_i    = 64'd0;
    cordic_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      trans_id_i = TRANS_ID_W'(k + 4);
      exp_q.push_back(64'h0000_0000_4000_0000);
      tol_q.push_back(TOL);
      exp_id_q.push_back(TRANS_ID_W'(k + 4));
      exp_cyc_q.push_back(cyc + LAT);
      repeat (ITER + 2) tick();
    end
    cordic_valid_i = 1'b0;
    repeat (ITER + 4) tick();

    check_val("scoreboard_drained", 64'(exp_cyc_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
